fp_solver_rr_arbiter: RTL
=========================

// Module: fp_solver_rr_arbiter
// PURPOSE
//  Shares one fp_equation_solver core among NUM_REQ requesters (CPU AXI-lite
//  slave, DMA feeder, self-test engine). Requesters arbitrate round-robin. The
//  winner's operands are latched and the core is started, then monitored with
//  a timeout. The result/flags are routed back to the owner only.
// PARAMETERS
//  NUM_REQ      4     number of requesters (2..8)
//  DATA_W       32    operand/result width (IEEE-754 single)
//  TIMEOUT_CYC  1024  max cycles in WAIT before forced error completion
// PORTS
//  ACLK         in   1               clock, all logic on rising edge
//  ARESETN      in   1               async active-low reset
//  req_valid    in   NUM_REQ         per-requester job request
//  req_ready    out  NUM_REQ         one-hot accept pulse (operands taken)
//  req_opa      in   NUM_REQ*DATA_W  operand A, requester i at [i*DATA_W+:DATA_W]
//  req_opb      in   NUM_REQ*DATA_W  operand B, same packing
//  req_opc      in   NUM_REQ*DATA_W  operand C, same packing
//  rsp_valid    out  NUM_REQ         one-hot result pulse to owner
//  rsp_result   out  DATA_W          result, valid with rsp_valid
//  rsp_flags    out  4               core flags {inv,ovf,unf,inexact}
//  rsp_err      out  1               1 = timeout completion
//  core_start   out  1               1-cycle start pulse to solver
//  core_abort   out  1               1-cycle abort pulse on timeout
//  core_a/b/c   out  DATA_W each     registered operands to solver
//  core_busy    in   1               solver busy
//  core_done    in   1               1-cycle completion pulse
//  core_result  in   DATA_W          solver result
//  core_flags   in   4               solver flags
//  arb_busy     out  1               1 when state != IDLE
//  grant_id     out  $clog2(NUM_REQ) current/last owner index
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr pointer last=NUM_REQ-1 (req 0 wins first);
//   timeout counter 0. Mid-op reset drops the job, no rsp_valid is issued.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: when |req_valid && !core_busy, pick first valid index searching
//   last+1, last+2,... mod NUM_REQ. Latch index into grant_id and operands into
//   core_a/b/c. Go to ISSUE. If core_busy=1, stay in IDLE (no grant).
//  ISSUE (1 cycle): core_start=1; req_ready[grant_id]=1; last<=grant_id; cnt<=0.
//   -> WAIT. Requester holds valid+operands stable until its req_ready pulse.
//   It may drop req_valid after the pulse.
//  WAIT: cnt increments each cycle. core_done=1 -> capture core_result/flags,
//   err=0, -> RESP. cnt==TIMEOUT_CYC-1 without done -> core_abort=1 for 1 cycle,
//   result=32'h7FC00000, flags=4'b1000, err=1, -> RESP. Done in the same cycle
//   as expiry: done wins, no abort.
//  RESP (1 cycle): rsp_valid[grant_id]=1 with rsp_result/flags/err held stable
//   until the next RESP. -> IDLE.
//  core_done outside WAIT is ignored.
//  req_valid from the current owner during WAIT/RESP is a new job; it
//   re-arbitrates in IDLE behind other valid requesters.
//  Latency: req_valid seen in IDLE at edge t -> core_start/req_ready at t+1.
//   core_done at edge d -> rsp_valid at d+1.
//   Min turnaround, done 1 cycle after start: 4 cycles, IDLE to IDLE.
//  Fairness: with all NUM_REQ valid continuously, grants rotate 0,1,2,3,0...
//   No requester waits more than NUM_REQ-1 jobs.
//  arb_busy=1 in ISSUE/WAIT/RESP. Widths are fixed, no arithmetic on data.
// TESTING
//  1 Single job: req_valid=4'b0001, A=3F800000 B=40000000 C=40400000, core
//    done after 5 cyc, result 3F800000 -> req_ready[0] once, core_start once,
//    rsp_valid=4'b0001, rsp_result=3F800000, rsp_err=0.
//  2 All 4 requesters valid from reset, 8 jobs -> grant_id 0,1,2,3,0,1,2,3;
//    each rsp_valid one-hot matches grant.
//  3 Core never asserts done, TIMEOUT_CYC=16 -> core_abort 16 cyc after start,
//    rsp_result=7FC00000, rsp_flags=1000, rsp_err=1.
//  4 core_done on the exact expiry cycle -> no core_abort, rsp_err=0,
//    core result returned.
//  5 ARESETN low during WAIT of req 2 -> outputs 0, no rsp_valid. After release
//    with req 2 and req 3 valid, req 2 wins because pointer reset to 3.
//  6 core_busy=1 with req_valid=4'b0100 -> no core_start until busy drops,
//    then start on the next cycle.

Source files
------------

// File: rtl/fp_solver_rr_arbiter.sv
// fp_solver_rr_arbiter
//   Shares one fp_equation_solver core among NUM_REQ requesters. Requesters are
//   granted round-robin. The winner's operands are latched, the core is started
//   and watched with a timeout, and the result is returned to the owner only.
//
// Ports
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester job request / one-hot accept pulse
//   req_opa/opb/opc        packed operands, requester i at [i*DATA_W +: DATA_W]
//   rsp_valid              one-hot result pulse to the owner
//   rsp_result/flags/err   response payload, held until the next response
//   core_start/core_abort  1-cycle start / timeout-abort pulses to the solver
//   core_a/b/c             registered operands to the solver
//   core_busy/done         solver status / 1-cycle completion pulse
//   core_result/flags      solver outputs, captured on core_done
//   arb_busy               high whenever a job is in flight
//   grant_id               current or last owner index
module fp_solver_rr_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1024,
    localparam int unsigned IdxW       = $clog2(NUM_REQ)
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_opa,
    input  logic [NUM_REQ*DATA_W-1:0] req_opb,
    input  logic [NUM_REQ*DATA_W-1:0] req_opc,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_result,
    output logic [3:0]                rsp_flags,
    output logic                      rsp_err,
    output logic                      core_start,
    output logic                      core_abort,
    output logic [DATA_W-1:0]         core_a,
    output logic [DATA_W-1:0]         core_b,
    output logic [DATA_W-1:0]         core_c,
    input  logic                      core_busy,
    input  logic                      core_done,
    input  logic [DATA_W-1:0]         core_result,
    input  logic [3:0]                core_flags,
    output logic                      arb_busy,
    output logic [IdxW-1:0]           grant_id
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [31:0] QNaN = 32'h7FC0_0000;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     last_q;
    logic [IdxW-1:0]     grant_q;
    logic [CntW-1:0]     cnt_q;
    logic [DATA_W-1:0]   core_a_q, core_b_q, core_c_q;
    logic [DATA_W-1:0]   result_q;
    logic [3:0]          flags_q;
    logic                err_q;

    logic                pick_found;
    logic [IdxW-1:0]     pick_idx;
    int unsigned         scan_idx;
    logic                take;
    logic                expired;

    // Search last+1, last+2, ... so the previous owner is considered last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            scan_idx = (32'(last_q) + off) % NUM_REQ;
            if (!pick_found && req_valid[IdxW'(scan_idx)]) begin
                pick_found = 1'b1;
                pick_idx   = IdxW'(scan_idx);
            end
        end
    end

    assign take    = (state_q == StIdle) && pick_found && !core_busy;
    assign expired = (cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d    = state_q;
        core_abort = 1'b0;
        unique case (state_q)
            StIdle:  if (take) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait: begin
                // A done arriving on the expiry cycle wins over the abort.
                if (core_done) begin
                    state_d = StResp;
                end else if (expired) begin
                    state_d    = StResp;
                    core_abort = 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= StIdle;
            last_q   <= IdxW'(NUM_REQ - 1);
            grant_q  <= '0;
            cnt_q    <= '0;
            core_a_q <= '0;
            core_b_q <= '0;
            core_c_q <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (take) begin
                        grant_q  <= pick_idx;
                        core_a_q <= req_opa[int'(pick_idx) * DATA_W +: DATA_W];
                        core_b_q <= req_opb[int'(pick_idx) * DATA_W +: DATA_W];
                        core_c_q <= req_opc[int'(pick_idx) * DATA_W +: DATA_W];
                    end
                end
                StIssue: begin
                    last_q <= grant_q;
                    cnt_q  <= '0;
                end
                StWait: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (core_done) begin
                        result_q <= core_result;
                        flags_q  <= core_flags;
                        err_q    <= 1'b0;
                    end else if (expired) begin
                        result_q <= DATA_W'(QNaN);
                        flags_q  <= 4'b1000;
                        err_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state_q == StIssue) ? (NUM_REQ'(1) << grant_q) : '0;
    assign rsp_valid  = (state_q == StResp) ? (NUM_REQ'(1) << grant_q) : '0;
    assign core_start = (state_q == StIssue);
    assign arb_busy   = (state_q != StIdle);
    assign grant_id   = grant_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign core_c     = core_c_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign rsp_err    = err_q;

endmodule
